// File: rtl/res_station.sv
// Arithmetic reservation station: tagged operand entries, CDB wakeup, one registered ALU issue per cycle.
// Optional RES_STATION_AGE_PRIORITY_EN selects the oldest ready entry instead of the lowest index.
module res_station #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [3:0]        disp_op,
  input  logic [2:0]        disp_funct3,
  input  logic              disp_funct7,
  input  logic [TAG_W-1:0]  disp_src1_tag,
  input  logic [TAG_W-1:0]  disp_src2_tag,
  input  logic [31:0]       disp_src1_data,
  input  logic [31:0]       disp_src2_data,
  input  logic              disp_src1_valid,
  input  logic              disp_src2_valid,
  input  logic [TAG_W-1:0]  disp_rd_tag,
  input  logic [31:0]       disp_pc,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [31:0]       cdb_data,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [3:0]        alu_op,
  output logic [2:0]        alu_funct3,
  output logic              alu_funct7,
  output logic [31:0]       alu_src1_data,
  output logic [31:0]       alu_src2_data,
  output logic [31:0]       alu_pc,
  output logic [TAG_W-1:0]  alu_tag,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [3:0]       op;
    logic [2:0]       funct3;
    logic             funct7;
    logic             s1_valid;
    logic [TAG_W-1:0] s1_tag;
    logic [31:0]      s1_data;
    logic             s2_valid;
    logic [TAG_W-1:0] s2_tag;
    logic [31:0]      s2_data;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      pc;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] rdy;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_fire;
  logic             issue_load;
  logic             byp1;
  logic             byp2;
  entry_t           disp_ent;

`ifdef RES_STATION_AGE_PRIORITY_EN
  // age = number of busy entries dispatched after this one; unique among busy entries
  logic [IDX_W-1:0] age_q [DEPTH];
  logic [IDX_W-1:0] best_age;
`endif

  assign disp_ready = (occupancy < OCC_W'(DEPTH));
  assign disp_fire  = disp_valid & disp_ready & free_found;
  assign issue_load = sel_found & (~alu_valid | alu_ready);

  // lowest-index free slot, judged on pre-edge state only
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    rdy = '0;
    for (int i = 0; i < DEPTH; i++)
      rdy[i] = busy_q[i] & ent_q[i].s1_valid & ent_q[i].s2_valid;
  end

`ifdef RES_STATION_AGE_PRIORITY_EN
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    best_age  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i] && (!sel_found || age_q[i] > best_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age_q[i];
      end
    end
  end
`else
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  // dispatch payload with same-cycle CDB bypass
  always_comb begin
    byp1 = ~disp_src1_valid & cdb_valid & (cdb_tag == disp_src1_tag);
    byp2 = ~disp_src2_valid & cdb_valid & (cdb_tag == disp_src2_tag);
    disp_ent          = '0;
    disp_ent.op       = disp_op;
    disp_ent.funct3   = disp_funct3;
    disp_ent.funct7   = disp_funct7;
    disp_ent.s1_valid = disp_src1_valid | byp1;
    disp_ent.s1_tag   = disp_src1_tag;
    disp_ent.s1_data  = byp1 ? cdb_data : disp_src1_data;
    disp_ent.s2_valid = disp_src2_valid | byp2;
    disp_ent.s2_tag   = disp_src2_tag;
    disp_ent.s2_data  = byp2 ? cdb_data : disp_src2_data;
    disp_ent.rd_tag   = disp_rd_tag;
    disp_ent.pc       = disp_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q        <= '0;
      occupancy     <= '0;
      alu_valid     <= 1'b0;
      alu_op        <= '0;
      alu_funct3    <= '0;
      alu_funct7    <= 1'b0;
      alu_src1_data <= '0;
      alu_src2_data <= '0;
      alu_pc        <= '0;
      alu_tag       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
`ifdef RES_STATION_AGE_PRIORITY_EN
        age_q[i] <= '0;
`endif
      end
    end else if (flush) begin
      busy_q    <= '0;
      occupancy <= '0;
      alu_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && cdb_valid) begin
          if (!ent_q[i].s1_valid && ent_q[i].s1_tag == cdb_tag) begin
            ent_q[i].s1_valid <= 1'b1;
            ent_q[i].s1_data  <= cdb_data;
          end
          if (!ent_q[i].s2_valid && ent_q[i].s2_tag == cdb_tag) begin
            ent_q[i].s2_valid <= 1'b1;
            ent_q[i].s2_data  <= cdb_data;
          end
        end
`ifdef RES_STATION_AGE_PRIORITY_EN
        if (busy_q[i] && !(issue_load && IDX_W'(i) == sel_idx))
          age_q[i] <= age_q[i] + IDX_W'(disp_fire)
                      - IDX_W'(issue_load && (age_q[i] > age_q[sel_idx]));
`endif
      end

      if (issue_load) begin
        busy_q[sel_idx] <= 1'b0;
        alu_valid       <= 1'b1;
        alu_op          <= ent_q[sel_idx].op;
        alu_funct3      <= ent_q[sel_idx].funct3;
        alu_funct7      <= ent_q[sel_idx].funct7;
        alu_src1_data   <= ent_q[sel_idx].s1_data;
        alu_src2_data   <= ent_q[sel_idx].s2_data;
        alu_pc          <= ent_q[sel_idx].pc;
        alu_tag         <= ent_q[sel_idx].rd_tag;
      end else if (alu_ready) begin
        alu_valid <= 1'b0;
      end

      if (disp_fire) begin
        busy_q[free_idx] <= 1'b1;
        ent_q[free_idx]  <= disp_ent;
`ifdef RES_STATION_AGE_PRIORITY_EN
        age_q[free_idx]  <= '0;
`endif
      end

      occupancy <= occupancy + OCC_W'(disp_fire) - OCC_W'(issue_load);
    end
  end

endmodule

// File: tb/tb_res_station.sv
// Scoreboard bench for res_station: directed dispatch/CDB/backpressure/flush/reset scenarios.
module tb_res_station;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 3;

  typedef struct {
    logic [3:0]       op;
    logic [2:0]       f3;
    logic             f7;
    logic [31:0]      s1;
    logic [31:0]      s2;
    logic [31:0]      pc;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              disp_valid = 1'b0;
  logic              disp_ready;
  logic [3:0]        disp_op = '0;
  logic [2:0]        disp_funct3 = '0;
  logic              disp_funct7 = 1'b0;
  logic [TAG_W-1:0]  disp_src1_tag = '0, disp_src2_tag = '0, disp_rd_tag = '0;
  logic [31:0]       disp_src1_data = '0, disp_src2_data = '0, disp_pc = '0;
  logic              disp_src1_valid = 1'b0, disp_src2_valid = 1'b0;
  logic              cdb_valid = 1'b0;
  logic [TAG_W-1:0]  cdb_tag = '0;
  logic [31:0]       cdb_data = '0;
  logic              alu_valid;
  logic              alu_ready = 1'b0;
  logic [3:0]        alu_op;
  logic [2:0]        alu_funct3;
  logic              alu_funct7;
  logic [31:0]       alu_src1_data, alu_src2_data, alu_pc;
  logic [TAG_W-1:0]  alu_tag;
  logic [$clog2(DEPTH):0] occupancy;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  res_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_funct3(disp_funct3), .disp_funct7(disp_funct7),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_data(disp_src1_data), .disp_src2_data(disp_src2_data),
    .disp_src1_valid(disp_src1_valid), .disp_src2_valid(disp_src2_valid),
    .disp_rd_tag(disp_rd_tag), .disp_pc(disp_pc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_op(alu_op), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_src1_data(alu_src1_data), .alu_src2_data(alu_src2_data),
    .alu_pc(alu_pc), .alu_tag(alu_tag), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // monitor: every accepted ALU word must match the oldest expected word
  always @(negedge clk) begin
    if (rst && alu_valid && alu_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_issue: got tag=%0d s1=%h s2=%h, required no issue",
                 alu_tag, alu_src1_data, alu_src2_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (alu_op !== e.op || alu_funct3 !== e.f3 || alu_funct7 !== e.f7 ||
            alu_src1_data !== e.s1 || alu_src2_data !== e.s2 ||
            alu_pc !== e.pc || alu_tag !== e.tag)
        begin
          fails++;
          $display("FAIL issue_word: got op=%h f3=%0d f7=%0b s1=%h s2=%h pc=%h tag=%0d, required op=%h f3=%0d f7=%0b s1=%h s2=%h pc=%h tag=%0d",
                   alu_op, alu_funct3, alu_funct7, alu_src1_data, alu_src2_data, alu_pc, alu_tag,
                   e.op, e.f3, e.f7, e.s1, e.s2, e.pc, e.tag);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive_disp(input logic [3:0] op, input logic [2:0] f3, input logic f7,
                            input logic v1, input logic [TAG_W-1:0] t1, input logic [31:0] d1,
                            input logic v2, input logic [TAG_W-1:0] t2, input logic [31:0] d2,
                            input logic [TAG_W-1:0] rd, input logic [31:0] pc,
                            input logic [31:0] e1, input logic [31:0] e2, input bit push);
    exp_t e;
    disp_valid = 1'b1;
    disp_op = op; disp_funct3 = f3; disp_funct7 = f7;
    disp_src1_valid = v1; disp_src1_tag = t1; disp_src1_data = d1;
    disp_src2_valid = v2; disp_src2_tag = t2; disp_src2_data = d2;
    disp_rd_tag = rd; disp_pc = pc;
    if (push) begin
      e.op = op; e.f3 = f3; e.f7 = f7; e.s1 = e1; e.s2 = e2; e.pc = pc; e.tag = rd;
      sb.push_back(e);
    end
  endtask

  task automatic idle_disp();
    disp_valid = 1'b0;
    disp_src1_valid = 1'b0;
    disp_src2_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // reset / idle
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("reset_alu_valid", 32'(alu_valid), 32'd0);
    chk("reset_occupancy", 32'(occupancy), 32'd0);
    chk("reset_disp_ready", 32'(disp_ready), 32'd1);
    chk("reset_alu_src1", alu_src1_data, 32'd0);

    // ready dispatch: N -> busy N+1 -> alu_valid N+2
    alu_ready = 1'b1;
    drive_disp(4'h1, 3'd0, 1'b0, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd7, 3'd2, 32'h1000,
               32'd5, 32'd7, 1'b1);
    step(); idle_disp();
    chk("ready_occ_n1", 32'(occupancy), 32'd1);
    chk("ready_valid_n1", 32'(alu_valid), 32'd0);
    step();
    chk("ready_valid_n2", 32'(alu_valid), 32'd1);
    chk("ready_occ_n2", 32'(occupancy), 32'd0);
    step();
    chk("ready_valid_n3", 32'(alu_valid), 32'd0);

    // CDB wakeup; a non-matching tag must not wake the entry
    drive_disp(4'h2, 3'd4, 1'b1, 1'b0, 3'd3, 32'hDEAD, 1'b1, 3'd0, 32'd9, 3'd5, 32'h1004,
               32'h100, 32'd9, 1'b1);
    step(); idle_disp();
    step(); cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 32'h55;
    step(); cdb_valid = 1'b0;
    step();
    chk("wake_wrong_tag", 32'(alu_valid), 32'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'h100;
    step(); cdb_valid = 1'b0;
    chk("wake_m1", 32'(alu_valid), 32'd0);
    step();
    chk("wake_m2", 32'(alu_valid), 32'd1);
    step();

    // both operands of one entry woken by the same broadcast
    drive_disp(4'h3, 3'd1, 1'b0, 1'b0, 3'd2, 32'h0, 1'b0, 3'd2, 32'h0, 3'd6, 32'h1008,
               32'h77, 32'h77, 1'b1);
    step(); idle_disp();
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'h77;
    step(); cdb_valid = 1'b0;
    step();
    chk("wake_both_m2", 32'(alu_valid), 32'd1);
    step();

    // dispatch-cycle CDB bypass
    drive_disp(4'h1, 3'd7, 1'b0, 1'b0, 3'd6, 32'h0, 1'b1, 3'd0, 32'h3, 3'd1, 32'h100C,
               32'hAA, 32'h3, 1'b1);
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 32'hAA;
    step(); idle_disp(); cdb_valid = 1'b0;
    chk("bypass_n1", 32'(alu_valid), 32'd0);
    step();
    chk("bypass_n2", 32'(alu_valid), 32'd1);
    step();

    // full / backpressure: op0 into issue register, ops 1..4 fill the station
    alu_ready = 1'b0;
    drive_disp(4'h1, 3'd0, 1'b0, 1'b1, 3'd0, 32'h10, 1'b1, 3'd0, 32'h20, 3'd0, 32'h2000,
               32'h10, 32'h20, 1'b1);
    step(); idle_disp();
    step();
    for (int k = 1; k <= 4; k++) begin
      drive_disp(4'h2, 3'(k), 1'b0, 1'b1, 3'd0, 32'(k), 1'b1, 3'd0, 32'(k * 16),
                 3'(k), 32'h2000 + 32'(4 * k), 32'(k), 32'(k * 16), 1'b1);
      step();
    end
    idle_disp();
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_disp_ready", 32'(disp_ready), 32'd0);
    // dispatch attempt while full must be dropped
    drive_disp(4'h4, 3'd3, 1'b1, 1'b1, 3'd0, 32'hBAD, 1'b1, 3'd0, 32'hBAD, 3'd7, 32'hBAD0,
               32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_valid", 32'(alu_valid), 32'd1);
      chk("hold_tag", 32'(alu_tag), 32'd0);
      chk("hold_src2", alu_src2_data, 32'h20);
    end
    idle_disp();
    chk("hold_occ", 32'(occupancy), 32'd4);
    alu_ready = 1'b1;
    drain("drain_order");
    step();
    chk("drain_occ", 32'(occupancy), 32'd0);
    chk("drain_valid", 32'(alu_valid), 32'd0);

    // flush with 3 busy entries and a held issue word; same-cycle dispatch is dropped
    alu_ready = 1'b0;
    drive_disp(4'h1, 3'd0, 1'b0, 1'b1, 3'd0, 32'h1, 1'b1, 3'd0, 32'h2, 3'd0, 32'h3000,
               32'h0, 32'h0, 1'b0);
    step(); idle_disp();
    step();
    for (int k = 1; k <= 3; k++) begin
      drive_disp(4'h1, 3'd0, 1'b0, 1'b1, 3'd0, 32'(k), 1'b1, 3'd0, 32'(k), 3'(k), 32'h3000,
                 32'h0, 32'h0, 1'b0);
      step();
    end
    idle_disp();
    chk("preflush_occ", 32'(occupancy), 32'd3);
    chk("preflush_valid", 32'(alu_valid), 32'd1);
    flush = 1'b1;
    drive_disp(4'h1, 3'd0, 1'b0, 1'b1, 3'd0, 32'h9, 1'b1, 3'd0, 32'h9, 3'd5, 32'h3010,
               32'h0, 32'h0, 1'b0);
    step(); flush = 1'b0; idle_disp();
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_valid", 32'(alu_valid), 32'd0);
    alu_ready = 1'b1;
    repeat (3) step();
    chk("postflush_valid", 32'(alu_valid), 32'd0);

    // station still works after flush
    drive_disp(4'h5, 3'd2, 1'b1, 1'b1, 3'd0, 32'hCAFE, 1'b1, 3'd0, 32'hBEEF, 3'd4, 32'h4000,
               32'hCAFE, 32'hBEEF, 1'b1);
    step(); idle_disp();
    drain("postflush_issue");
    step();

    // async reset between clock edges
    alu_ready = 1'b0;
    drive_disp(4'h1, 3'd0, 1'b0, 1'b1, 3'd0, 32'h11, 1'b1, 3'd0, 32'h22, 3'd3, 32'h5000,
               32'h0, 32'h0, 1'b0);
    step();
    drive_disp(4'h1, 3'd0, 1'b0, 1'b1, 3'd0, 32'h33, 1'b1, 3'd0, 32'h44, 3'd4, 32'h5004,
               32'h0, 32'h0, 1'b0);
    step(); idle_disp();
    step();
    chk("prereset_valid", 32'(alu_valid), 32'd1);
    chk("prereset_occ", 32'(occupancy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 32'(alu_valid), 32'd0);
    chk("async_rst_occ", 32'(occupancy), 32'd0);
    chk("async_rst_src1", alu_src1_data, 32'd0);
    chk("async_rst_tag", 32'(alu_tag), 32'd0);
    step(); step();
    rst = 1'b1;
    alu_ready = 1'b1;
    step();
    chk("final_disp_ready", 32'(disp_ready), 32'd1);
    repeat (3) step();
    chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

// File: doc/res_station.md
Name: res_station

Overview:
- Arithmetic reservation station of the Tomasulo core, between dispatch (rename/ROB allocate) and the ALU.
- Holds up to DEPTH instructions with tagged operands and snoops the common data bus (CDB) for missing operands.
- Issues one ready instruction per cycle to the ALU through a registered valid/ready port carrying the ALU word fields.

Parameters:
- DEPTH, 4, number of station entries (power of two, 2..8)
- TAG_W, 3, ROB tag width (8 ROB entries)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- flush  input  1  synchronous kill of all entries and the issue register
- disp_valid  input  1  dispatch request
- disp_ready  output  1  station can accept this cycle
- disp_op  input  4  op_t encoding
- disp_funct3  input  3  funct3
- disp_funct7  input  1  funct7 bit
- disp_src1_tag / disp_src2_tag  input  TAG_W  producer ROB tag when operand not valid
- disp_src1_data / disp_src2_data  input  32  operand value when valid
- disp_src1_valid / disp_src2_valid  input  1  operand already available
- disp_rd_tag  input  TAG_W  destination ROB tag
- disp_pc  input  32  instruction PC
- cdb_valid  input  1  CDB broadcast this cycle
- cdb_tag  input  TAG_W  broadcasting ROB tag
- cdb_data  input  32  broadcast value
- alu_valid  output  1  issue register holds an instruction
- alu_ready  input  1  ALU accepts
- alu_op  output  4  op
- alu_funct3  output  3  funct3
- alu_funct7  output  1  funct7 bit
- alu_src1_data / alu_src2_data  output  32  operands
- alu_pc  output  32  PC
- alu_tag  output  TAG_W  destination ROB tag
- occupancy  output  $clog2(DEPTH)+1  busy entry count, excluding the issue register

Behaviour:
- Reset (rst=0, async): all entries invalid; alu_valid=0; all alu_* data outputs 0; occupancy=0; disp_ready=1 once reset is released.
- disp_ready = (occupancy < DEPTH), combinational from registered state only. It does not look ahead to same-cycle frees.
- Dispatch fires on disp_valid & disp_ready and writes the lowest-index free entry at the clock edge.
- Dispatch CDB bypass: if a dispatched operand has valid=0 and cdb_valid & cdb_tag==src_tag in the same cycle, the entry stores cdb_data with valid=1.
- CDB snoop: each busy entry operand with valid=0 and a matching tag captures cdb_data and sets valid at the edge. Both operands of one entry may match together.
- An entry is ready when busy and both operands are valid.
- Selection: lowest-index ready entry (default; see Optional Feature).
- The issue register loads the selected entry when (!alu_valid | alu_ready). The entry frees at the same edge.
- alu_valid and all alu_* outputs stay stable while alu_valid & !alu_ready.
- Latency with operands valid at dispatch: dispatch in cycle N, entry busy in N+1, alu_valid in N+2. An operand broadcast on the CDB in cycle M produces alu_valid at M+2 at the earliest.
- Throughput: 1 issue/cycle while alu_ready=1.
- Simultaneous dispatch and issue-free: both happen. The dispatch uses a slot that was free before the edge, never the one being freed.
- occupancy next = occupancy + dispatch_fire - issue_load.
- The issue register does not snoop the CDB; its operands are complete by construction.
- flush: at the next edge all entries are invalid, alu_valid=0, occupancy=0, and dispatch in that cycle is dropped. flush takes priority over every other event.
- Async reset mid-operation clears state immediately, regardless of clk.
- Store ops (op MSB=1) are not dispatched here. Behaviour for them is undefined and the bench does not drive them.

Optional Feature:
- Macro RES_STATION_AGE_PRIORITY_EN.
- Defined: each entry carries an age counter of $clog2(DEPTH) bits, set to 0 on dispatch and incremented for older entries. Selection picks the ready entry with the greatest age (oldest first); ties cannot occur.
- Undefined: lowest-index ready entry wins and no age state exists.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, then release -> alu_valid=0, occupancy=0, disp_ready=1.
- Ready dispatch: in cycle N dispatch op=ARITH, funct3=0, src1=5, src2=7 (both valid), rd_tag=2, alu_ready=1 -> in N+2 alu_valid=1, alu_src1_data=5, alu_src2_data=7, alu_tag=2; occupancy back to 0.
- CDB wakeup: dispatch with src1 waiting on tag 3, src2=9 valid; two cycles later cdb_valid=1, tag=3, data=0x100 -> alu_valid two cycles after the broadcast with src1=0x100. A broadcast with tag 4 produces no issue.
- Dispatch bypass: dispatch src1 tag 6, valid=0, with cdb_valid=1, tag=6, data=0xAA in the same cycle -> issues at N+2 with src1=0xAA.
- Full/backpressure: alu_ready=0, dispatch 5 ready ops -> first loads the issue register; next 4 fill the station, occupancy=4, disp_ready=0. Outputs hold steady; raising alu_ready drains in order tags 0,1,2,3,4 (tag 4 last).
- Flush: with 3 entries busy and alu_valid=1, pulse flush -> next cycle occupancy=0, alu_valid=0. Also assert rst=0 mid-stream between clk edges -> outputs clear immediately.
